operand_line_packer: RTL and testbench

- Upstream of the systolic engine's operand buffers.
- Collects the 32-bit host writes (write strobe, word address, word data, A/B select) into memory lines of systolic_size words each.
- Issues each line as one wide write to the A-operand RAM or the B-operand RAM.
- Also raises a host-visible status and a partial-line flush, so the engine can be started with `go` only once every operand line has landed.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/operand_line_packer.sv | 165 ++++++++++++++++
 tb/tb_operand_line_packer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the systolic operand path.
// Widths here match the default line geometry (4 lanes, 16-bit line address).
package systolic_pkg;

    localparam int LANE_W = 2;
    localparam int LINE_W = 16;

    typedef logic [LANE_W-1:0] lane_idx_t;
    typedef logic [LINE_W-1:0] line_addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    function automatic bit line_width_ok(input int data_size,
                                         input int systolic_size,
                                         input int memory_data_size);
        return memory_data_size == data_size * systolic_size;
    endfunction

endpackage

// File: rtl/operand_line_packer.sv
// Packs single host words into systolic_size-wide operand RAM lines and issues
// each line as one registered write, full on completion or partial on eviction/flush.
module operand_line_packer
    import systolic_pkg::*;
#(
    parameter int data_size        = 32,
    parameter int systolic_size    = 4,
    parameter int memory_data_size = 128,
    parameter int ADDR_W           = 2,
    parameter int LINE_AW          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wready_q,
    input  logic [31:0]                 write_addr,
    input  logic [31:0]                 hello_world_q,
    input  logic                        A_cho,
    input  logic                        B_cho,
    input  logic                        flush,
    output logic                        mem_we_a,
    output logic                        mem_we_b,
    output logic [LINE_AW-1:0]          mem_addr,
    output logic [memory_data_size-1:0] mem_wdata,
    output logic [systolic_size-1:0]    mem_wmask,
    output logic [15:0]                 lines_written,
    output logic                        busy,
    output logic                        sel_err
);

    if (!line_width_ok(data_size, systolic_size, memory_data_size)) begin : g_bad_width
        $error("memory_data_size must equal data_size*systolic_size");
    end
    if (systolic_size < 2 || (1 << ADDR_W) != systolic_size) begin : g_bad_lanes
        $error("systolic_size must be a power of two >= 2 with ADDR_W = log2(systolic_size)");
    end

    typedef logic [systolic_size-1:0][data_size-1:0] line_t;

    fill_state_e              state_q, state_d;
    logic [LINE_AW-1:0]       line_q, line_d;
    logic                     bank_q, bank_d;
    line_t                    buf_q, buf_d, merged;
    logic [systolic_size-1:0] mask_q, mask_d, merged_mask;

    logic                     accept, keep_old;
    logic [ADDR_W-1:0]        in_lane;
    logic [LINE_AW-1:0]       in_line;
    logic                     same_line;

    logic                     emit, emit_bank;
    logic [LINE_AW-1:0]       emit_addr;
    line_t                    emit_data;
    logic [systolic_size-1:0] emit_mask;

    logic                     we_a_q, we_b_q;
    logic [LINE_AW-1:0]       addr_q;
    line_t                    wdata_q;
    logic [systolic_size-1:0] wmask_q;
    logic [15:0]              lines_q;
    logic                     sel_err_q;

    assign accept    = wready_q && (A_cho != B_cho);
    assign in_lane   = write_addr[ADDR_W-1:0];
    assign in_line   = write_addr[ADDR_W+LINE_AW-1:ADDR_W];
    assign same_line = (state_q == FILL) && (in_line == line_q) && (B_cho == bank_q);
    // The open line survives this cycle unless a word for another line/bank evicts it.
    assign keep_old  = (state_q == FILL) && (!accept || same_line);

    for (genvar l = 0; l < systolic_size; l++) begin : g_lane
        logic lane_hit;
        assign lane_hit       = accept && (in_lane == ADDR_W'(l));
        assign merged[l]      = lane_hit ? hello_world_q[data_size-1:0]
                                         : (keep_old ? buf_q[l] : '0);
        assign merged_mask[l] = lane_hit || (keep_old && mask_q[l]);
    end

    if (ADDR_W + LINE_AW < 32) begin : g_unused_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^write_addr[31:ADDR_W+LINE_AW];
    end
    if (data_size < 32) begin : g_unused_data
        logic unused_data_bits;
        assign unused_data_bits = ^hello_world_q[31:data_size];
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        bank_d    = bank_q;
        buf_d     = buf_q;
        mask_d    = mask_q;
        emit      = 1'b0;
        emit_bank = bank_q;
        emit_addr = line_q;
        emit_data = buf_q;
        emit_mask = mask_q;

        if (accept) begin
            buf_d   = merged;
            mask_d  = merged_mask;
            state_d = FILL;
            if (!keep_old) begin
                // Eviction writes the old line out as-is while the new word opens a fresh one.
                line_d = in_line;
                bank_d = B_cho;
                emit   = (state_q == FILL);
            end
        end

        if (keep_old && ((accept && &merged_mask) || flush)) begin
            emit      = 1'b1;
            emit_data = merged;
            emit_mask = merged_mask;
            state_d   = IDLE;
            buf_d     = '0;
            mask_d    = '0;
        end
    end

    // NOTE: the line buffer is reset with the rest of the state so stale lanes can never
    // leak into a later partial write; it is a handful of flops, not a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            bank_q    <= 1'b0;
            buf_q     <= '0;
            mask_q    <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            lines_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples
            // the pre-edge values, independent of statement order.
            state_q <= state_d;
            line_q  <= line_d;
            bank_q  <= bank_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            we_a_q  <= emit && !emit_bank;
            we_b_q  <= emit && emit_bank;
            addr_q  <= emit ? emit_addr : '0;
            wdata_q <= emit ? emit_data : '0;
            wmask_q <= emit ? emit_mask : '0;
            lines_q <= lines_q + 16'(emit);
            if (wready_q && (A_cho == B_cho)) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign mem_we_a      = we_a_q;
    assign mem_we_b      = we_b_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign lines_written = lines_q;
    assign busy          = (state_q == FILL);
    assign sel_err       = sel_err_q;

endmodule

// File: tb/tb_operand_line_packer.sv
// Directed self-checking bench for operand_line_packer: line writes are captured by
// a monitor and compared against hand-computed expectations.
module tb_operand_line_packer;
    import systolic_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         wready_q;
    logic [31:0]  write_addr;
    logic [31:0]  hello_world_q;
    logic         A_cho, B_cho, flush;
    logic         mem_we_a, mem_we_b;
    line_addr_t   mem_addr;
    logic [127:0] mem_wdata;
    logic [3:0]   mem_wmask;
    logic [15:0]  lines_written;
    logic         busy, sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]   bank;
        line_addr_t   addr;
        logic [127:0] data;
        logic [3:0]   mask;
        time          t;
    } wr_t;
    wr_t wq[$];

    localparam logic [127:0] STREAM_LINE = 128'h00000000_00000003_00000002_00000001;

    operand_line_packer dut (
        .clk(clk), .reset(reset), .wready_q(wready_q), .write_addr(write_addr),
        .hello_world_q(hello_world_q), .A_cho(A_cho), .B_cho(B_cho), .flush(flush),
        .mem_we_a(mem_we_a), .mem_we_b(mem_we_b), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .lines_written(lines_written),
        .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we_a || mem_we_b)
            wq.push_back('{bank: {mem_we_b, mem_we_a}, addr: mem_addr, data: mem_wdata,
                           mask: mem_wmask, t: $time});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic word(input logic [31:0] addr, input logic [31:0] data,
                        input logic a, input logic b, input logic fl = 1'b0);
        wready_q      = 1'b1;
        write_addr    = addr;
        hello_world_q = data;
        A_cho         = a;
        B_cho         = b;
        flush         = fl;
        @(posedge clk); #1;
        wready_q = 1'b0;
        A_cho    = 1'b0;
        B_cho    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wready_q = 1'b0;
        A_cho    = 1'b0;
        B_cho    = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [1:0] bank, input line_addr_t addr,
                                input logic [127:0] data, input logic [3:0] mask);
        wr_t w;
        if (wq.size() == 0) begin
            check({tag, " present"}, 0, 1);
        end else begin
            w = wq.pop_front();
            check({tag, " bank"}, w.bank, bank);
            check({tag, " addr"}, w.addr, addr);
            check({tag, " data"}, w.data, data);
            check({tag, " mask"}, w.mask, mask);
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, " extra writes"}, wq.size(), 0);
        wq.delete();
    endtask

    initial begin
        time t_start;
        wr_t w;
        write_addr    = '0;
        hello_world_q = '0;
        do_reset();

        // reset state
        check("rst we_a", mem_we_a, 0);
        check("rst we_b", mem_we_b, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst wmask", mem_wmask, 0);
        check("rst lines", lines_written, 0);
        check("rst busy", busy, 0);
        check("rst sel_err", sel_err, 0);

        // full-line A stream, back to back
        t_start = $time;
        for (int i = 0; i < 64; i++) word(i, (i + 1) % 4, 1'b1, 1'b0);
        idle(3);
        check("A stream count", wq.size(), 16);
        if (wq.size() > 0) check("A first write latency", wq[0].t - t_start, 44);
        for (int i = 0; i < 16; i++)
            expect_write($sformatf("A line %0d", i), 2'b01, line_addr_t'(i), STREAM_LINE, 4'hF);
        expect_none("A stream");
        check("A lines_written", lines_written, 16);
        check("A idle wmask", mem_wmask, 0);
        check("A idle wdata", mem_wdata, 0);
        check("A busy after", busy, 0);

        // same stream to B
        do_reset();
        for (int i = 0; i < 64; i++) word(i, (i + 1) % 4, 1'b0, 1'b1);
        idle(3);
        check("B stream count", wq.size(), 16);
        for (int i = 0; i < 16; i++)
            expect_write($sformatf("B line %0d", i), 2'b10, line_addr_t'(i), STREAM_LINE, 4'hF);
        expect_none("B stream");
        check("B lines_written", lines_written, 16);

        // eviction of a partial line, then flush
        do_reset();
        word(4, 32'h44, 1'b1, 1'b0);
        word(5, 32'h55, 1'b1, 1'b0);
        check("evict busy open", busy, 1);
        word(12, 32'hCC, 1'b1, 1'b0);
        idle(2);
        expect_write("evict", 2'b01, 16'd1, 128'h00000000_00000000_00000055_00000044, 4'b0011);
        expect_none("evict");
        check("evict busy new line", busy, 1);
        pulse_flush();
        idle(2);
        expect_write("flush", 2'b01, 16'd3, 128'h000000CC, 4'b0001);
        expect_none("flush");
        check("flush busy", busy, 0);
        check("flush lines", lines_written, 2);

        // flush merged with a same-line word, with a different-line word, and in IDLE
        word(8, 32'h80, 1'b1, 1'b0);
        word(9, 32'h90, 1'b1, 1'b0, 1'b1);
        idle(2);
        expect_write("flush+same", 2'b01, 16'd2, 128'h00000090_00000080, 4'b0011);
        expect_none("flush+same");
        check("flush+same busy", busy, 0);
        word(8, 32'hA8, 1'b0, 1'b1);
        word(16, 32'hB0, 1'b0, 1'b1, 1'b1);
        idle(2);
        expect_write("flush+diff", 2'b10, 16'd2, 128'h000000A8, 4'b0001);
        expect_none("flush+diff");
        check("flush+diff busy", busy, 1);
        pulse_flush();
        idle(2);
        expect_write("flush new", 2'b10, 16'd4, 128'h000000B0, 4'b0001);
        pulse_flush();
        idle(2);
        expect_none("flush idle");
        check("flush idle lines", lines_written, 5);

        // ambiguous select
        do_reset();
        word(0, 32'hDEAD, 1'b1, 1'b1);
        idle(2);
        expect_none("sel both");
        check("sel_err set", sel_err, 1);
        check("sel busy", busy, 0);
        for (int i = 0; i < 4; i++) word(i, 32'h20 + i, 1'b1, 1'b0);
        idle(2);
        expect_write("after sel_err", 2'b01, 16'd0, 128'h00000023_00000022_00000021_00000020, 4'hF);
        expect_none("after sel_err");
        check("sel_err sticky", sel_err, 1);

        // reset mid-fill discards the open line
        do_reset();
        check("reset clears sel_err", sel_err, 0);
        for (int i = 0; i < 3; i++) word(i, 32'h30 + i, 1'b1, 1'b0);
        do_reset();
        idle(2);
        expect_none("mid-fill reset");
        check("mid-fill lines", lines_written, 0);
        check("mid-fill busy", busy, 0);
        for (int i = 0; i < 4; i++) word(i, 32'h10 + i, 1'b1, 1'b0);
        idle(2);
        expect_write("post reset", 2'b01, 16'd0, 128'h00000013_00000012_00000011_00000010, 4'hF);
        expect_none("post reset");

        // lane rewrite, last write wins
        do_reset();
        word(0, 32'd1, 1'b1, 1'b0);
        word(3, 32'd7, 1'b1, 1'b0);
        word(1, 32'd2, 1'b1, 1'b0);
        word(3, 32'd9, 1'b1, 1'b0);
        check("rewrite still open", busy, 1);
        word(2, 32'd3, 1'b1, 1'b0);
        idle(2);
        expect_write("rewrite", 2'b01, 16'd0, 128'h00000009_00000003_00000002_00000001, 4'hF);
        expect_none("rewrite");
        check("rewrite lines", lines_written, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
